// File: rtl/kaiser_pkg.sv
// rtl/kaiser_pkg.sv - shared core definitions: condition codes and resolver FSM states
package kaiser_pkg;

  typedef enum logic [2:0] {
    COND_NV = 3'd0,
    COND_AL = 3'd1,
    COND_EQ = 3'd2,
    COND_NE = 3'd3,
    COND_LT = 3'd4,
    COND_LE = 3'd5,
    COND_GT = 3'd6,
    COND_GE = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_REDIR = 2'd2
  } dbr_state_e;

  localparam int NUM_SLOTS = 2;

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational branch-condition evaluator over N/V/Z flags
module cond_eval
  import kaiser_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       v,
  input  logic       z,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_NV: taken = 1'b0;
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_LT: taken = n ^ v;
      COND_LE: taken = z | (n ^ v);
      COND_GT: taken = ~z & ~(n ^ v);
      COND_GE: taken = ~(n ^ v);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/vDFF_en.sv
// rtl/vDFF_en.sv - enabled D flip-flop bank primitive, no built-in reset
module vDFF_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/delayed_branch_resolver.sv
// rtl/delayed_branch_resolver.sv - two-slot delayed-branch resolver: S2/S3 entry pipe,
// flag-wait FSM and one-cycle redirect pulse.
module delayed_branch_resolver
  import kaiser_pkg::*;
#(
  parameter int PC_W   = 9,
  parameter int DEST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic [DEST_W-1:0] p0_delayed_B_1in,
  input  logic [DEST_W-1:0] p1_delayed_B_1in,
  input  logic [2:0]        p0_delayed_cond_1in,
  input  logic [2:0]        p1_delayed_cond_1in,
  input  logic              N,
  input  logic              V,
  input  logic              Z,
  input  logic              flags_valid,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_PC,
  output logic              redirect_IR0_invalid,
  output logic              flush,
  output logic              stall_req
);

  // entry layout: {valid, dest, cond}
  localparam int ENT_W = 1 + DEST_W + 3;

  dbr_state_e state, next_state;
  logic [PC_W-1:0] dest_lat;

  logic [ENT_W-1:0]  cap   [NUM_SLOTS];
  logic [ENT_W-1:0]  s2_q  [NUM_SLOTS];
  logic [ENT_W-1:0]  s2_d  [NUM_SLOTS];
  logic [ENT_W-1:0]  s3_q  [NUM_SLOTS];
  logic [ENT_W-1:0]  s3_d  [NUM_SLOTS];
  logic              s2_en, s3_en;

  logic [NUM_SLOTS-1:0] s3_valid;
  logic [NUM_SLOTS-1:0] cond_hit;
  logic [DEST_W-1:0]    s3_dest [NUM_SLOTS];
  logic [2:0]           s3_cond [NUM_SLOTS];

  logic any_s3, hit0, hit1, any_taken, resolve, adv_eff, clear_all;
  logic [DEST_W-1:0] sel_dest;

  assign cap[0] = {p0_delayed_cond_1in != COND_NV, p0_delayed_B_1in, p0_delayed_cond_1in};
  assign cap[1] = {p1_delayed_cond_1in != COND_NV, p1_delayed_B_1in, p1_delayed_cond_1in};

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    vDFF_en #(.W(ENT_W)) u_s2 (.clk(clk), .en(s2_en), .d(s2_d[gi]), .q(s2_q[gi]));
    vDFF_en #(.W(ENT_W)) u_s3 (.clk(clk), .en(s3_en), .d(s3_d[gi]), .q(s3_q[gi]));

    assign s3_valid[gi] = s3_q[gi][ENT_W-1];
    assign s3_dest[gi]  = s3_q[gi][ENT_W-2:3];
    assign s3_cond[gi]  = s3_q[gi][2:0];
  end

  cond_eval u_eval_p0 (.cond(s3_cond[0]), .n(N), .v(V), .z(Z), .taken(cond_hit[0]));
  cond_eval u_eval_p1 (.cond(s3_cond[1]), .n(N), .v(V), .z(Z), .taken(cond_hit[1]));

  // p0 has priority; a taken p0 discards p1 without looking at it
  assign any_s3    = |s3_valid;
  assign hit0      = s3_valid[0] & cond_hit[0];
  assign hit1      = s3_valid[1] & cond_hit[1] & ~hit0;
  assign any_taken = hit0 | hit1;
  assign sel_dest  = hit0 ? s3_dest[0] : s3_dest[1];
  assign resolve   = ~rst & (state == ST_RUN || state == ST_HOLD) & any_s3 & flags_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst)                        dest_lat <= '0;
    else if (resolve && any_taken)  dest_lat <= PC_W'(sel_dest);
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_RUN: begin
        if (any_s3 && !flags_valid)      next_state = ST_HOLD;
        else if (resolve && any_taken)   next_state = ST_REDIR;
      end
      ST_HOLD: begin
        if (flags_valid) next_state = any_taken ? ST_REDIR : ST_RUN;
      end
      ST_REDIR: next_state = ST_RUN;
      default:  next_state = ST_RUN;
    endcase
  end

  always_comb begin
    redirect_valid       = 1'b0;
    flush                = 1'b0;
    stall_req            = 1'b0;
    redirect_PC          = '0;
    redirect_IR0_invalid = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN:  stall_req = any_s3 & ~flags_valid;
        ST_HOLD: stall_req = ~flags_valid;
        ST_REDIR: begin
          redirect_valid       = 1'b1;
          flush                = 1'b1;
          redirect_PC          = {dest_lat[PC_W-1:1], 1'b0};
          redirect_IR0_invalid = dest_lat[0];
        end
        default: ;
      endcase
    end
  end

  // a pending S3 entry is frozen while waiting for flags, even if advance is driven
  assign adv_eff   = advance & ~stall_req;
  assign clear_all = rst | redirect_valid;
  assign s2_en     = clear_all | adv_eff;
  assign s3_en     = clear_all | adv_eff | resolve;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      s2_d[i] = clear_all ? '0 : cap[i];
      s3_d[i] = (clear_all || !adv_eff) ? '0 : s2_q[i];
    end
  end

endmodule

// File: tb/tb_delayed_branch_resolver.sv
// tb/tb_delayed_branch_resolver.sv - directed and random checks of the resolver against a pipeline model
module tb_delayed_branch_resolver;

  logic        clk = 1'b0;
  logic        rst, advance, N, V, Z, flags_valid;
  logic [15:0] p0_b, p1_b;
  logic [2:0]  p0_c, p1_c;
  logic        redirect_valid, redirect_IR0_invalid, flush, stall_req;
  logic [8:0]  redirect_PC;

  delayed_branch_resolver #(.PC_W(9), .DEST_W(16)) dut (
    .clk(clk), .rst(rst), .advance(advance),
    .p0_delayed_B_1in(p0_b), .p1_delayed_B_1in(p1_b),
    .p0_delayed_cond_1in(p0_c), .p1_delayed_cond_1in(p1_c),
    .N(N), .V(V), .Z(Z), .flags_valid(flags_valid),
    .redirect_valid(redirect_valid), .redirect_PC(redirect_PC),
    .redirect_IR0_invalid(redirect_IR0_invalid), .flush(flush), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          v;
    logic [15:0] d;
    logic [2:0]  c;
  } ent_t;

  ent_t        m_s2[2];
  ent_t        m_s3[2];
  bit          m_redir = 1'b0;
  logic [15:0] m_dest = '0;

  bit          e_rv, e_fl, e_st, e_ir0;
  logic [8:0]  e_pc;

  function automatic bit m_taken(logic [2:0] c, bit n, bit v, bit z);
    case (c)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return z;
      3'd3: return !z;
      3'd4: return n != v;
      3'd5: return z || (n != v);
      3'd6: return !z && (n == v);
      default: return n == v;
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(bit r, bit adv, logic [2:0] c0, logic [15:0] d0,
                      logic [2:0] c1, logic [15:0] d1, bit n, bit v, bit z, bit fv);
    ent_t cap[2];
    bit   has, fired, a;
    @(negedge clk);
    rst = r; advance = adv; p0_c = c0; p0_b = d0; p1_c = c1; p1_b = d1;
    N = n; V = v; Z = z; flags_valid = fv;
    #1;
    has  = m_s3[0].v || m_s3[1].v;
    e_rv = 0; e_fl = 0; e_st = 0; e_ir0 = 0; e_pc = '0;
    if (!r) begin
      if (m_redir) begin
        e_rv = 1; e_fl = 1; e_pc = {m_dest[8:1], 1'b0}; e_ir0 = m_dest[0];
      end else begin
        e_st = has && !fv;
      end
    end
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    chk("flush", 32'(flush), 32'(e_fl));
    chk("stall_req", 32'(stall_req), 32'(e_st));
    chk("redirect_PC", 32'(redirect_PC), 32'(e_pc));
    chk("redirect_IR0_invalid", 32'(redirect_IR0_invalid), 32'(e_ir0));

    cap[0].v = (c0 != 3'd0); cap[0].d = d0; cap[0].c = c0;
    cap[1].v = (c1 != 3'd0); cap[1].d = d1; cap[1].c = c1;
    if (r || m_redir) begin
      for (int i = 0; i < 2; i++) begin m_s2[i].v = 0; m_s3[i].v = 0; end
      m_redir = 0;
    end else begin
      a = adv && !e_st;
      fired = 0;
      if (has && fv) begin
        for (int i = 0; i < 2; i++)
          if (!fired && m_s3[i].v && m_taken(m_s3[i].c, n, v, z)) begin
            fired = 1; m_dest = m_s3[i].d;
          end
        m_redir = fired;
      end
      if (a) m_s3 = m_s2;
      else if (has && fv) begin m_s3[0].v = 0; m_s3[1].v = 0; end
      if (a) m_s2 = cap;
    end
  endtask

  task automatic idle(bit adv, bit n, bit v, bit z, bit fv);
    step(0, adv, 3'd0, 16'h0, 3'd0, 16'h0, n, v, z, fv);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin m_s2[i] = '{0, '0, '0}; m_s3[i] = '{0, '0, '0}; end
    rst = 1; advance = 0; p0_c = 0; p1_c = 0; p0_b = 0; p1_b = 0;
    N = 0; V = 0; Z = 0; flags_valid = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3'd1, 16'h11, 3'd1, 16'h22, 0, 0, 0, 1);
    chk("reset_rv", 32'(redirect_valid), 0);
    chk("reset_stall", 32'(stall_req), 0);

    // EQ taken on p0
    step(0, 1, 3'd2, 16'h0012, 3'd0, 16'h0, 0, 0, 1, 1);
    idle(1, 0, 0, 1, 1);
    idle(0, 0, 0, 1, 1);
    idle(0, 0, 0, 0, 1);
    chk("eq_rv", 32'(redirect_valid), 1);
    chk("eq_pc", 32'(redirect_PC), 32'h012);
    chk("eq_ir0", 32'(redirect_IR0_invalid), 0);
    chk("eq_flush", 32'(flush), 1);
    idle(0, 0, 0, 0, 1);
    chk("eq_single_pulse", 32'(redirect_valid), 0);

    // p0 NV, p1 GE with odd destination
    step(0, 1, 3'd0, 16'h0, 3'd7, 16'h0025, 1, 1, 0, 1);
    idle(1, 1, 1, 0, 1);
    idle(0, 1, 1, 0, 1);
    idle(0, 0, 0, 0, 1);
    chk("ge_pc", 32'(redirect_PC), 32'h024);
    chk("ge_ir0", 32'(redirect_IR0_invalid), 1);

    // p0 LT taken suppresses p1 AL
    step(0, 1, 3'd4, 16'h0030, 3'd1, 16'h0050, 1, 0, 0, 1);
    idle(1, 1, 0, 0, 1);
    idle(0, 1, 0, 0, 1);
    idle(0, 1, 0, 0, 1);
    chk("lt_rv", 32'(redirect_valid), 1);
    chk("lt_pc", 32'(redirect_PC), 32'h030);
    idle(0, 1, 0, 0, 1);
    chk("lt_no_second_a", 32'(redirect_valid), 0);
    idle(0, 1, 0, 0, 1);
    chk("lt_no_second_b", 32'(redirect_valid), 0);

    // wait for flags three cycles, then GT taken
    step(0, 1, 3'd6, 16'h0040, 3'd0, 16'h0, 0, 0, 0, 1);
    idle(1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      idle(1, 0, 0, 0, 0);
      chk("hold_stall", 32'(stall_req), 1);
    end
    idle(0, 0, 0, 0, 1);
    chk("hold_release", 32'(stall_req), 0);
    idle(0, 0, 0, 0, 1);
    chk("gt_rv", 32'(redirect_valid), 1);
    chk("gt_pc", 32'(redirect_PC), 32'h040);

    // entry held in S2 by advance=0
    step(0, 1, 3'd1, 16'h0062, 3'd0, 16'h0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      idle(0, 0, 0, 0, 1);
      chk("s2_hold_rv", 32'(redirect_valid), 0);
    end
    idle(1, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 1);
    chk("s2_resume_rv", 32'(redirect_valid), 1);
    chk("s2_resume_pc", 32'(redirect_PC), 32'h062);

    // reset during HOLD aborts the branch
    step(0, 1, 3'd1, 16'h0070, 3'd0, 16'h0, 0, 0, 0, 1);
    idle(1, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 0);
    chk("pre_rst_stall", 32'(stall_req), 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 1);
    chk("post_rst_rv", 32'(redirect_valid), 0);
    chk("post_rst_stall", 32'(stall_req), 0);
    step(0, 1, 3'd1, 16'h0088, 3'd0, 16'h0, 0, 0, 0, 1);
    idle(1, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 1);
    chk("post_rst_al_pc", 32'(redirect_PC), 32'h088);

    // destination wider than PC truncates
    step(0, 1, 3'd1, 16'hFFFF, 3'd0, 16'h0, 0, 0, 0, 1);
    idle(1, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 1);
    idle(0, 0, 0, 0, 1);
    chk("trunc_pc", 32'(redirect_PC), 32'h1FE);
    chk("trunc_ir0", 32'(redirect_IR0_invalid), 1);

    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) < 7,
           3'($urandom_range(0, 7)), 16'($urandom),
           3'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
